cu_decoder: RTL and testbench

CU_DECODER -- requirements
Module: cu_decoder

---
 rtl/cu_pkg.sv | 26 ++
 rtl/cu_decoder.sv | 48 ++++
 tb/tb_cu_decoder.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared control-unit sizing defaults and named CPU state indices
package cu_pkg;

    localparam int CU_N      = 6;
    localparam int CU_STATES = 40;

    // Step indices shared by the CU sequencer and the datapath.
    localparam int ST_FETCH0  = 0;
    localparam int ST_FETCH1  = 1;
    localparam int ST_FETCH2  = 2;
    localparam int ST_DECODE  = 3;
    localparam int ST_ADDR0   = 4;
    localparam int ST_ADDR1   = 5;
    localparam int ST_READ0   = 6;
    localparam int ST_READ1   = 7;
    localparam int ST_EXEC0   = 8;
    localparam int ST_EXEC1   = 9;
    localparam int ST_EXEC2   = 10;
    localparam int ST_WRITE0  = 11;
    localparam int ST_WRITE1  = 12;
    localparam int ST_BRANCH  = 13;
    localparam int ST_IRQ0    = 14;
    localparam int ST_IRQ1    = 15;
    localparam int ST_HALT    = CU_STATES - 1;

endpackage

// File: rtl/cu_decoder.sv
// rtl/cu_decoder.sv - one-hot decode of the CU step counter with registered copy and sticky error
module cu_decoder
    import cu_pkg::*;
#(
    parameter int N      = CU_N,
    parameter int STATES = CU_STATES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      counter_value,
    output logic [STATES-1:0] CPU_state,
    output logic [STATES-1:0] CPU_state_q,
    output logic              illegal_state,
    output logic              illegal_state_q
);

    // The one-hot output must be able to represent every counter code it is asked to decode.
    generate
        if (STATES < 1 || STATES > (2 ** N)) begin : g_bad_params
            $fatal(1, "cu_decoder: STATES must satisfy 1 <= STATES <= 2**N");
        end
    endgenerate

    // One bit wider than the counter so that STATES == 2**N is representable.
    localparam logic [N:0] STATES_LIMIT = (N+1)'(STATES);

    // Full-width compare per state bit; X on the counter propagates rather than defaulting.
    always_comb begin
        CPU_state = '0;
        for (int i = 0; i < STATES; i++) begin
            CPU_state[i] = (counter_value == N'(i));
        end
    end

    assign illegal_state = ({1'b0, counter_value} >= STATES_LIMIT);

    // Registered state copy and sticky illegal flag, both cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            CPU_state_q     <= '0;
            illegal_state_q <= 1'b0;
        end else begin
            CPU_state_q     <= CPU_state;
            illegal_state_q <= illegal_state_q | illegal_state;
        end
    end

endmodule

// File: tb/tb_cu_decoder.sv
// tb/tb_cu_decoder.sv - scoreboard bench for cu_decoder at default and N=3/STATES=8 sizes
module tb_cu_decoder;

    logic        clk;
    logic        rst;
    logic [5:0]  counter_value;
    logic [39:0] cpu_state;
    logic [39:0] cpu_state_q;
    logic        illegal;
    logic        illegal_q;

    logic [2:0]  counter_b;
    logic [7:0]  cpu_state_b;
    logic [7:0]  cpu_state_q_b;
    logic        illegal_b;
    logic        illegal_q_b;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        int          sel;
        logic [63:0] exp;
    } exp_t;

    exp_t sb[$];
    event sample_ev;

    cu_decoder dut (
        .clk            (clk),
        .rst            (rst),
        .counter_value  (counter_value),
        .CPU_state      (cpu_state),
        .CPU_state_q    (cpu_state_q),
        .illegal_state  (illegal),
        .illegal_state_q(illegal_q)
    );

    cu_decoder #(.N(3), .STATES(8)) dut_b (
        .clk            (clk),
        .rst            (rst),
        .counter_value  (counter_b),
        .CPU_state      (cpu_state_b),
        .CPU_state_q    (cpu_state_q_b),
        .illegal_state  (illegal_b),
        .illegal_state_q(illegal_q_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // At most one state bit may be set at any time, in both instances.
    always @(negedge clk or posedge clk) begin
        total++;
        if ($countones(cpu_state) > 1 || $countones(cpu_state_b) > 1) begin
            bad++;
            $display("FAIL onehot t=%0t actual a=%h b=%h required at most one bit set",
                     $time, cpu_state, cpu_state_b);
        end
    end

    // Monitor: on each sample request, drain the scoreboard against live DUT outputs.
    initial begin
        exp_t        e;
        logic [63:0] act;
        forever begin
            @(sample_ev);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.sel)
                    0:       act = 64'(cpu_state);
                    1:       act = 64'(illegal);
                    2:       act = 64'(cpu_state_q);
                    3:       act = 64'(illegal_q);
                    4:       act = 64'(cpu_state_b);
                    default: act = 64'(illegal_b);
                endcase
                total++;
                if (act !== e.exp) begin
                    bad++;
                    $display("FAIL %s t=%0t actual=%h required=%h", e.name, $time, act, e.exp);
                end
            end
        end
    end

    task automatic expect_val(input string name, input int sel, input logic [63:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic check_now();
        ->sample_ev;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        counter_value = 6'd0;
        counter_b     = 3'd0;

        // Reset state, held across clock edges.
        #3;
        expect_val("rst_q", 2, 64'h0);
        expect_val("rst_illq", 3, 64'h0);
        expect_val("rst_comb", 0, 64'h1);
        check_now();
        @(posedge clk); #1;
        expect_val("rst_q_edge", 2, 64'h0);
        check_now();

        // Release on a negedge; first edge loads the decode of counter 0.
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        expect_val("first_load", 2, 64'h1);
        check_now();

        // Legal sweep 0..39: one-hot, no error, registered copy follows.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk) counter_value = 6'(i);
            #10;
            expect_val($sformatf("sweep_cs_%0d", i), 0, 64'h1 << i);
            expect_val($sformatf("sweep_ill_%0d", i), 1, 64'h0);
            expect_val($sformatf("sweep_q_%0d", i), 2, 64'h1 << i);
            expect_val($sformatf("sweep_illq_%0d", i), 3, 64'h0);
            check_now();
        end

        // Registered copy has exactly one cycle of latency.
        @(negedge clk) counter_value = 6'd7;
        @(posedge clk); #1;
        expect_val("lat_q7", 2, 64'h80);
        check_now();
        counter_value = 6'd8;
        #1;
        expect_val("lat_cs8", 0, 64'h100);
        expect_val("lat_hold7", 2, 64'h80);
        check_now();
        @(posedge clk); #1;
        expect_val("lat_q8", 2, 64'h100);
        check_now();

        // Illegal codes: zero decode, combinational flag, sticky register.
        @(negedge clk) counter_value = 6'd40;
        #1;
        expect_val("ill40_cs", 0, 64'h0);
        expect_val("ill40_flag", 1, 64'h1);
        expect_val("ill40_q_not_yet", 3, 64'h0);
        check_now();
        counter_value = 6'd63;
        #1;
        expect_val("ill63_cs", 0, 64'h0);
        expect_val("ill63_flag", 1, 64'h1);
        check_now();
        @(posedge clk); #1;
        expect_val("ill_sticky_set", 3, 64'h1);
        expect_val("ill_q_zero", 2, 64'h0);
        check_now();
        @(negedge clk) counter_value = 6'd5;
        @(posedge clk); #1;
        expect_val("ill_sticky_hold", 3, 64'h1);
        expect_val("ill_clear_comb", 1, 64'h0);
        expect_val("back5_q", 2, 64'h20);
        check_now();

        // Mid-cycle reset clears registers without a clock edge.
        @(negedge clk) counter_value = 6'd7;
        @(posedge clk); #1;
        expect_val("pre_rst_q", 2, 64'h80);
        expect_val("pre_rst_illq", 3, 64'h1);
        check_now();
        rst = 1'b1;
        #1;
        expect_val("async_rst_q", 2, 64'h0);
        expect_val("async_rst_illq", 3, 64'h0);
        expect_val("async_rst_cs", 0, 64'h80);
        check_now();
        counter_value = 6'd9;
        #1;
        expect_val("rst_track_cs", 0, 64'h200);
        check_now();
        @(posedge clk); #1;
        expect_val("rst_hold_q", 2, 64'h0);
        check_now();
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        expect_val("post_rst_q", 2, 64'h200);
        expect_val("post_rst_illq", 3, 64'h0);
        check_now();

        // Full-code instance: STATES == 2**N, so every code is legal.
        for (int i = 0; i < 8; i++) begin
            counter_b = 3'(i);
            #10;
            expect_val($sformatf("b_cs_%0d", i), 4, 64'h1 << i);
            expect_val($sformatf("b_ill_%0d", i), 5, 64'h0);
            check_now();
        end

        for (int k = 0; k < 10 && sb.size() > 0; k++) #1;
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain actual=%0d pending required=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
